// File: rtl/cmd_bus_pkg.sv
// Shared opcodes, response codes, error subcodes and FSM states for the command bus master.
package cmd_bus_pkg;

    typedef enum logic [1:0] {
        OP_READ     = 2'b00,
        OP_WRITE    = 2'b01,
        OP_SET_ADDR = 2'b10,
        OP_ABORT    = 2'b11
    } opcode_e;

    localparam logic [1:0] RSP_WRITE_OK  = 2'b00;
    localparam logic [1:0] RSP_READ_DATA = 2'b01;
    localparam logic [1:0] RSP_ADDR      = 2'b10;
    localparam logic [1:0] RSP_ERROR     = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BUS     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RSP
    } state_e;

endpackage

// File: rtl/cmd_bus_timeout.sv
// Counts the cycles a bus transaction has been open; the count is 1 in the first wb_cyc cycle.
module cmd_bus_timeout
    import cmd_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Load 1 on start, then count up and saturate at TIMEOUT until cleared
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= CW'(1);
        end else if (clear) begin
            count <= '0;
        end else if ((count != '0) && (count != CW'(TIMEOUT))) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT));

endmodule

// File: rtl/cmd_bus_master.sv
// Host command interface driving a single pipelined Wishbone master transaction per command.
module cmd_bus_master
    import cmd_bus_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 30,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_stb,
    input  logic [DW+1:0]   cmd_word,
    output logic            cmd_busy,
    output logic            rsp_stb,
    output logic [DW+1:0]   rsp_word,
    output logic            wb_cyc,
    output logic            wb_stb,
    output logic            wb_we,
    output logic [AW-1:0]   wb_addr,
    output logic [DW-1:0]   wb_data,
    output logic [DW/8-1:0] wb_sel,
    input  logic            wb_stall,
    input  logic            wb_ack,
    input  logic            wb_err,
    input  logic [DW-1:0]   wb_idata
);

    state_e        state;
    state_e        state_next;
    opcode_e       cmd_op;
    logic [DW-1:0] cmd_payload;
    logic          accept;
    logic [AW-1:0] addr;
    logic          inc_dis;
    logic [AW-1:0] set_addr_value;
    logic [DW-1:0] addr_payload;
    logic          tmo_start;
    logic          tmo_clear;
    logic          tmo_expired;
    logic          rsp_load;
    logic [DW+1:0] rsp_next;
    logic          addr_inc;

    assign cmd_op      = opcode_e'(cmd_word[DW+1:DW]);
    assign cmd_payload = cmd_word[DW-1:0];
    assign cmd_busy    = (state != ST_IDLE);
    assign accept      = cmd_stb && !cmd_busy;
    assign wb_cyc      = (state == ST_REQ) || (state == ST_WAIT);
    assign wb_stb      = (state == ST_REQ);
    assign rsp_stb     = (state == ST_RSP);
    assign wb_addr     = addr;
    assign wb_sel      = '1;

    // New address for a set-address command and the payload echoed back in its response
    always_comb begin
        set_addr_value = cmd_payload[AW-1:0];
        if (cmd_payload[DW-1]) begin
            set_addr_value = addr + cmd_payload[AW-1:0];
        end
        addr_payload           = '0;
        addr_payload[AW-1:0]   = set_addr_value;
        addr_payload[DW-2]     = cmd_payload[DW-2];
    end

    // Next-state, response selection and timeout control
    always_comb begin
        state_next = state;
        rsp_load   = 1'b0;
        rsp_next   = rsp_word;
        addr_inc   = 1'b0;
        tmo_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_READ, OP_WRITE: begin
                            state_next = ST_REQ;
                            tmo_start  = 1'b1;
                        end
                        OP_SET_ADDR: begin
                            state_next = ST_RSP;
                            rsp_load   = 1'b1;
                            rsp_next   = {RSP_ADDR, addr_payload};
                        end
                        OP_ABORT: begin
                            state_next = ST_RSP;
                            rsp_load   = 1'b1;
                            rsp_next   = {RSP_ERROR, {(DW-2){1'b0}}, ERR_ABORT};
                        end
                    endcase
                end
            end
            ST_REQ: begin
                if (tmo_expired) begin
                    state_next = ST_RSP;
                    rsp_load   = 1'b1;
                    rsp_next   = {RSP_ERROR, {(DW-2){1'b0}}, ERR_TIMEOUT};
                end else if (!wb_stall) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wb_err) begin
                    state_next = ST_RSP;
                    rsp_load   = 1'b1;
                    rsp_next   = {RSP_ERROR, {(DW-2){1'b0}}, ERR_BUS};
                end else if (wb_ack) begin
                    state_next = ST_RSP;
                    rsp_load   = 1'b1;
                    addr_inc   = !inc_dis;
                    if (wb_we) begin
                        rsp_next = {RSP_WRITE_OK, {DW{1'b0}}};
                    end else begin
                        rsp_next = {RSP_READ_DATA, wb_idata};
                    end
                end else if (tmo_expired) begin
                    state_next = ST_RSP;
                    rsp_load   = 1'b1;
                    rsp_next   = {RSP_ERROR, {(DW-2){1'b0}}, ERR_TIMEOUT};
                end
            end
            ST_RSP: begin
                state_next = ST_IDLE;
            end
        endcase
        tmo_clear = (state_next == ST_IDLE) || (state_next == ST_RSP);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Address pointer, bus write controls and held response word
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr     <= '0;
            inc_dis  <= 1'b0;
            wb_we    <= 1'b0;
            wb_data  <= '0;
            rsp_word <= '0;
        end else begin
            if (rsp_load) begin
                rsp_word <= rsp_next;
            end
            if (accept && (cmd_op == OP_SET_ADDR)) begin
                addr    <= set_addr_value;
                inc_dis <= cmd_payload[DW-2];
            end else if (addr_inc) begin
                addr <= addr + AW'(1);
            end
            if (tmo_start) begin
                wb_we <= (cmd_op == OP_WRITE);
                if (cmd_op == OP_WRITE) begin
                    wb_data <= cmd_payload;
                end
            end else if (tmo_clear) begin
                wb_we <= 1'b0;
            end
        end
    end

    cmd_bus_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .start  (tmo_start),
        .clear  (tmo_clear),
        .expired(tmo_expired)
    );

endmodule

// File: tb/tb_cmd_bus_master.sv
// Randomized bench for cmd_bus_master with a transaction-level reference model.
module tb_cmd_bus_master;

    localparam int DW      = 32;
    localparam int AW      = 30;
    localparam int TIMEOUT = 255;
    localparam longint ADDR_SPAN = 64'd1 << AW;

    localparam logic [1:0] OPR = 2'b00;
    localparam logic [1:0] OPW = 2'b01;
    localparam logic [1:0] OPS = 2'b10;
    localparam logic [1:0] OPA = 2'b11;

    // kinds of slave reply
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic            clk      = 1'b0;
    logic            reset    = 1'b0;
    logic            cmd_stb  = 1'b0;
    logic [DW+1:0]   cmd_word = '0;
    logic            cmd_busy;
    logic            rsp_stb;
    logic [DW+1:0]   rsp_word;
    logic            wb_cyc;
    logic            wb_stb;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic [DW/8-1:0] wb_sel;
    logic            wb_stall = 1'b0;
    logic            wb_ack   = 1'b0;
    logic            wb_err   = 1'b0;
    logic [DW-1:0]   wb_idata = '0;

    int checks = 0;
    int errors = 0;

    longint model_addr = 0;
    bit     model_inc_en = 1'b1;

    cmd_bus_master #(
        .DW(DW),
        .AW(AW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cmd_stb (cmd_stb),
        .cmd_word(cmd_word),
        .cmd_busy(cmd_busy),
        .rsp_stb (rsp_stb),
        .rsp_word(rsp_word),
        .wb_cyc  (wb_cyc),
        .wb_stb  (wb_stb),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .wb_sel  (wb_sel),
        .wb_stall(wb_stall),
        .wb_ack  (wb_ack),
        .wb_err  (wb_err),
        .wb_idata(wb_idata)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issue one command, play the slave, and compare against the model's expectations.
    task automatic applyStimulus(input logic [1:0] op, input logic [DW-1:0] payload, input int stalls,
                                 input int ack_delay, input int kind, input logic [DW-1:0] slave_data,
                                 input bit poke_busy);
        logic [DW+1:0] exp_rsp;
        logic [DW+1:0] got_rsp;
        longint addr_before;
        int exp_rsp_cycle, exp_stb, exp_cyc;
        int stall_left, countdown, rsp_cycle, rsp_cnt, stb_cnt, cyc_cnt, busy_cnt;
        bit first_stb, done;

        addr_before   = model_addr;
        exp_stb       = 0;
        exp_cyc       = 0;
        exp_rsp_cycle = 1;
        exp_rsp       = '0;
        case (op)
            OPS: begin
                if (payload[DW-1]) model_addr = (model_addr + (longint'(payload) % ADDR_SPAN)) % ADDR_SPAN;
                else               model_addr = longint'(payload) % ADDR_SPAN;
                model_inc_en = !payload[DW-2];
                exp_rsp = {2'b10, DW'(model_addr + (payload[DW-2] ? (longint'(1) << (DW-2)) : longint'(0)))};
            end
            OPA: exp_rsp = {2'b11, DW'(3)};
            default: begin
                exp_stb = stalls + 1;
                if (kind == K_NONE) begin
                    exp_rsp_cycle = TIMEOUT + 1;
                    exp_rsp       = {2'b11, DW'(2)};
                end else begin
                    exp_rsp_cycle = stalls + 2 + ack_delay;
                    if (kind != K_ACK)  exp_rsp = {2'b11, DW'(1)};
                    else if (op == OPW) exp_rsp = '0;
                    else                exp_rsp = {2'b01, slave_data};
                    if (kind == K_ACK && model_inc_en) model_addr = (model_addr + 1) % ADDR_SPAN;
                end
                exp_cyc = exp_rsp_cycle - 1;
            end
        endcase

        @(negedge clk);
        cmd_stb    = 1'b1;
        cmd_word   = {op, payload};
        stall_left = stalls;
        countdown  = -1;
        rsp_cycle  = -1;
        rsp_cnt    = 0;
        stb_cnt    = 0;
        cyc_cnt    = 0;
        busy_cnt   = 0;
        first_stb  = 1'b1;
        done       = 1'b0;
        got_rsp    = '0;
        for (int n = 1; n <= TIMEOUT + 40 && !done; n++) begin
            @(negedge clk);
            if (cmd_busy) busy_cnt++;
            if (wb_cyc) cyc_cnt++;
            if (rsp_stb) begin
                rsp_cnt++;
                if (rsp_cycle < 0) begin
                    rsp_cycle = n;
                    got_rsp   = rsp_word;
                end
            end
            if (wb_stb) begin
                stb_cnt++;
                if (first_stb) begin
                    first_stb = 1'b0;
                    checkOutput("wbAddr", 64'(wb_addr), 64'(addr_before));
                    checkOutput("wbWe", 64'(wb_we), 64'(op == OPW));
                    if (op == OPW) checkOutput("wbData", 64'(wb_data), 64'(payload));
                    checkOutput("wbSel", 64'(wb_sel), 64'hF);
                end
            end
            if (rsp_cycle > 0 && n > rsp_cycle) done = 1'b1;
            wb_stall = 1'b0;
            wb_ack   = 1'b0;
            wb_err   = 1'b0;
            wb_idata = $urandom;
            if (wb_stb) begin
                if (stall_left > 0) begin
                    wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    countdown = ack_delay;
                end
            end else if (wb_cyc && countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    wb_ack   = (kind == K_ACK) || (kind == K_BOTH);
                    wb_err   = (kind == K_ERR) || (kind == K_BOTH);
                    wb_idata = slave_data;
                end
            end
            cmd_stb = poke_busy && cmd_busy && !rsp_stb && (rsp_cnt == 0);
            if (cmd_stb) cmd_word = {2'($urandom_range(0, 3)), DW'($urandom)};
        end
        cmd_stb = 1'b0;
        checkOutput("rspBound", 64'(done), 64'd1);
        checkOutput("rspWord", 64'(got_rsp), 64'(exp_rsp));
        checkOutput("rspCycle", 64'(rsp_cycle), 64'(exp_rsp_cycle));
        checkOutput("rspPulses", 64'(rsp_cnt), 64'd1);
        checkOutput("stbCycles", 64'(stb_cnt), 64'(exp_stb));
        checkOutput("cycCycles", 64'(cyc_cnt), 64'(exp_cyc));
        checkOutput("busyCycles", 64'(busy_cnt), 64'(exp_rsp_cycle));
        checkOutput("rspHold", 64'(rsp_word), 64'(exp_rsp));
    endtask

    // Pull reset low while a read waits for its ack, then deliver a late ack.
    task automatic resetMidWait();
        @(negedge clk);
        cmd_stb  = 1'b1;
        cmd_word = {OPR, DW'(0)};
        @(negedge clk);
        cmd_stb = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("cycBeforeReset", 64'(wb_cyc), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstCyc", 64'(wb_cyc), 64'd0);
        checkOutput("rstStb", 64'(wb_stb), 64'd0);
        checkOutput("rstWe", 64'(wb_we), 64'd0);
        checkOutput("rstBusy", 64'(cmd_busy), 64'd0);
        checkOutput("rstRspStb", 64'(rsp_stb), 64'd0);
        checkOutput("rstAddr", 64'(wb_addr), 64'd0);
        checkOutput("rstData", 64'(wb_data), 64'd0);
        checkOutput("rstRspWord", 64'(rsp_word), 64'd0);
        reset    = 1'b1;
        wb_ack   = 1'b1;
        wb_idata = $urandom;
        @(negedge clk);
        wb_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("lateAckRsp", 64'(rsp_stb), 64'd0);
            checkOutput("lateAckCyc", 64'(wb_cyc), 64'd0);
            @(negedge clk);
        end
        model_addr   = 0;
        model_inc_en = 1'b1;
    endtask

    initial begin
        int r, kind, timeouts_left;
        logic [DW-1:0] pl;

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("resetCyc", 64'(wb_cyc), 64'd0);
        checkOutput("resetStb", 64'(wb_stb), 64'd0);
        checkOutput("resetWe", 64'(wb_we), 64'd0);
        checkOutput("resetBusy", 64'(cmd_busy), 64'd0);
        checkOutput("resetRspStb", 64'(rsp_stb), 64'd0);
        checkOutput("resetAddr", 64'(wb_addr), 64'd0);
        checkOutput("resetData", 64'(wb_data), 64'd0);
        checkOutput("resetRspWord", 64'(rsp_word), 64'd0);
        reset = 1'b1;

        $display("[TB] directed sequence");
        applyStimulus(OPS, 32'h4000_0000, 0, 1, K_ACK, '0, 1'b0);
        applyStimulus(OPW, 32'hAABB_CCDD, 2, 1, K_ACK, '0, 1'b0);
        applyStimulus(OPR, 32'h0, 0, 1, K_ACK, 32'hAABB_CCDD, 1'b0);
        applyStimulus(OPS, 32'h3FFF_FFFF, 0, 1, K_ACK, '0, 1'b0);
        applyStimulus(OPR, 32'h0, 1, 2, K_ACK, 32'h1234_5678, 1'b0);
        applyStimulus(OPR, 32'h0, 0, 1, K_ACK, 32'h8765_4321, 1'b0);
        applyStimulus(OPR, 32'h0, 0, 1, K_NONE, '0, 1'b0);
        applyStimulus(OPW, 32'h5555_AAAA, 1, 2, K_BOTH, '0, 1'b1);
        applyStimulus(OPA, 32'hFFFF_FFFF, 0, 1, K_ACK, '0, 1'b1);
        applyStimulus(OPS, 32'h8000_0005, 0, 1, K_ACK, '0, 1'b0);
        applyStimulus(OPR, 32'h0, 0, 3, K_ERR, '0, 1'b0);
        applyStimulus(OPW, 32'hDEAD_BEEF, 3, 1, K_ACK, '0, 1'b0);

        $display("[TB] random sequence");
        timeouts_left = 2;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            kind = $urandom_range(0, 9);
            if (kind <= 6) kind = K_ACK;
            else if (kind == 7) kind = K_ERR;
            else if (kind == 8) kind = K_BOTH;
            else if (timeouts_left > 0) begin
                kind = K_NONE;
                timeouts_left--;
            end else kind = K_ACK;
            pl = $urandom;
            if (r == 7 || r == 8) begin
                if ($urandom_range(0, 1) == 1) pl[AW-1:0] = AW'(ADDR_SPAN - longint'($urandom_range(1, 3)));
                pl[DW-3:AW] = '0;
                applyStimulus(OPS, pl, 0, 1, K_ACK, '0, 1'($urandom_range(0, 1)));
            end else if (r == 9) begin
                applyStimulus(OPA, pl, 0, 1, K_ACK, '0, 1'($urandom_range(0, 1)));
            end else begin
                applyStimulus((r <= 3) ? OPR : OPW, pl, $urandom_range(0, 3), $urandom_range(1, 3),
                              kind, DW'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] reset during wait");
        resetMidWait();
        applyStimulus(OPR, 32'h0, 0, 1, K_ACK, 32'h0BAD_F00D, 1'b0);
        applyStimulus(OPR, 32'h0, 0, 1, K_ACK, 32'h600D_F00D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
